// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register in front of a shift register.
// Define UART_PARITY_EN to add a parity bit after the data bits (PARITY_ODD selects odd parity).
module uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 104,
  parameter int STOP_BITS    = 1
`ifdef UART_PARITY_EN
  ,
  parameter bit PARITY_ODD   = 1'b0
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] tx_i,
  input  logic                  tx_i_v,
  output logic                  tx_i_rdy,
  output logic                  tx_o,
  output logic                  tx_o_v
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         baud_cnt, baud_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic [DATA_WIDTH-1:0] shifter, shifter_n, shifted;
  logic [DATA_WIDTH-1:0] hold_data, hold_data_n;
  logic                  hold_full, hold_full_n;
  logic                  tx_q, tx_n;
  logic                  accept, baud_done, load, take_direct;
  logic [DATA_WIDTH-1:0] load_data;
`ifdef UART_PARITY_EN
  logic                  parity_q, parity_n;
`endif

  assign accept    = tx_i_v && !hold_full && !rst_i;
  assign baud_done = (baud_cnt == BAUD_LAST);
  assign shifted   = shifter >> 1;
  assign tx_i_rdy  = !hold_full;
  assign tx_o      = tx_q;
  assign tx_o_v    = (state != IDLE) || hold_full;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shifter   <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      tx_q      <= 1'b1;
`ifdef UART_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shifter   <= shifter_n;
      hold_data <= hold_data_n;
      hold_full <= hold_full_n;
      tx_q      <= tx_n;
`ifdef UART_PARITY_EN
      parity_q  <= parity_n;
`endif
    end
  end

  // tx_n is the line level for the cycle after this edge, so tx_o stays registered.
  always_comb begin
    state_n     = state;
    baud_n      = baud_done ? '0 : baud_cnt + 1'b1;
    bit_n       = bit_cnt;
    shifter_n   = shifter;
    hold_data_n = hold_data;
    hold_full_n = hold_full;
    tx_n        = tx_q;
    load        = 1'b0;
    load_data   = tx_i;
    take_direct = 1'b0;
`ifdef UART_PARITY_EN
    parity_n    = parity_q;
`endif

    case (state)
      IDLE: begin
        baud_n = '0;
        tx_n   = 1'b1;
        if (hold_full) begin
          load        = 1'b1;
          load_data   = hold_data;
          hold_full_n = 1'b0;
        end else if (accept) begin
          load        = 1'b1;
          take_direct = 1'b1;
        end
      end
      START: begin
        if (baud_done) begin
          state_n = DATA;
          bit_n   = '0;
          tx_n    = shifter[0];
        end
      end
      DATA: begin
        if (baud_done) begin
          if (bit_cnt == DATA_LAST) begin
            bit_n   = '0;
`ifdef UART_PARITY_EN
            state_n = PARITY;
            tx_n    = parity_q;
`else
            state_n = STOP;
            tx_n    = 1'b1;
`endif
          end else begin
            shifter_n = shifted;
            bit_n     = bit_cnt + 1'b1;
            tx_n      = shifted[0];
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (baud_done) begin
          state_n = STOP;
          bit_n   = '0;
          tx_n    = 1'b1;
        end
      end
`endif
      STOP: begin
        tx_n = 1'b1;
        if (baud_done) begin
          if (bit_cnt == STOP_LAST) begin
            // A waiting byte starts immediately so frames stay back-to-back.
            if (hold_full) begin
              load        = 1'b1;
              load_data   = hold_data;
              hold_full_n = 1'b0;
            end else if (accept) begin
              load        = 1'b1;
              take_direct = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (accept && !take_direct) begin
      hold_data_n = tx_i;
      hold_full_n = 1'b1;
    end

    if (load) begin
      state_n   = START;
      baud_n    = '0;
      bit_n     = '0;
      shifter_n = load_data;
      tx_n      = 1'b0;
`ifdef UART_PARITY_EN
      parity_n  = (^load_data) ^ PARITY_ODD;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: lane 0 uses one stop bit, lane 1 uses two.
// A sample-queue model predicts the line, busy and ready levels every cycle.
module tb_uart_tx;

  localparam int CPB = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME = 44;
`else
  localparam int FRAME = 40;
`endif

  logic       clk;
  logic       rst;
  logic [7:0] tx_i;
  logic [1:0] valid;
  logic [1:0] rdy;
  logic [1:0] line;
  logic [1:0] busy;

  int n_cmp = 0;
  int n_bad = 0;

  bit         q [2][$];
  bit         hold_f [2];
  logic [7:0] hold_d [2];
  bit         exp_tx [2];
  bit         exp_busy [2];
  bit         exp_rdy [2];

  bit line_s [100];
  bit busy_s [100];

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .tx_i(tx_i), .tx_i_v(valid[0]),
    .tx_i_rdy(rdy[0]), .tx_o(line[0]), .tx_o_v(busy[0])
  );

  uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut1 (
    .clk_i(clk), .rst_i(rst), .tx_i(tx_i), .tx_i_v(valid[1]),
    .tx_i_rdy(rdy[1]), .tx_o(line[1]), .tx_o_v(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("[TB] FAIL %s @%0t: got %0h, want %0h", name, $time, got, want);
    end
  endtask

  // A whole frame becomes one line sample per clock: start, data LSB first, parity, stops.
  task automatic push_frame(input int l, input logic [7:0] d);
    repeat (CPB) q[l].push_back(1'b0);
    for (int b = 0; b < 8; b++) repeat (CPB) q[l].push_back(d[b]);
`ifdef UART_PARITY_EN
    repeat (CPB) q[l].push_back(^d);
`endif
    repeat ((l + 1) * CPB) q[l].push_back(1'b1);
  endtask

  task automatic model_step(input int l);
    bit acc;
    if (rst) begin
      q[l].delete();
      hold_f[l]   = 1'b0;
      exp_tx[l]   = 1'b1;
      exp_busy[l] = 1'b0;
    end else begin
      acc = valid[l] && !hold_f[l];
      if (q[l].size() == 0) begin
        if (hold_f[l]) begin
          push_frame(l, hold_d[l]);
          hold_f[l] = 1'b0;
        end else if (acc) begin
          push_frame(l, tx_i);
          acc = 1'b0;
        end
      end
      if (acc) begin
        hold_f[l] = 1'b1;
        hold_d[l] = tx_i;
      end
      if (q[l].size() != 0) begin
        exp_tx[l]   = q[l].pop_front();
        exp_busy[l] = 1'b1;
      end else begin
        exp_tx[l]   = 1'b1;
        exp_busy[l] = hold_f[l];
      end
    end
    exp_rdy[l] = !hold_f[l];
  endtask

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) model_step(l);
    #1;
    for (int l = 0; l < 2; l++) begin
      check_output($sformatf("lane%0d tx_o", l), 32'(line[l]), 32'(exp_tx[l]));
      check_output($sformatf("lane%0d tx_o_v", l), 32'(busy[l]), 32'(exp_busy[l]));
      check_output($sformatf("lane%0d tx_i_rdy", l), 32'(rdy[l]), 32'(exp_rdy[l]));
    end
  end

  task automatic record(input int l, input int n);
    for (int i = 0; i < n; i++) begin
      line_s[i] = line[l];
      busy_s[i] = busy[l];
      @(negedge clk);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic [1:0] v);
    tx_i  = d;
    valid = v;
    @(negedge clk);
  endtask

  initial begin
    int cnt;
    int lows;
    logic [10:0] a5_bits;
    rst   = 1'b1;
    valid = 2'b00;
    tx_i  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 0xA5 from idle on lane 0, sampled mid-bit
`ifdef UART_PARITY_EN
    a5_bits = 11'b101_0010_1010;
`else
    a5_bits = 11'b000_1101_0010 | 11'b000_0000_0000;
    a5_bits = 11'b011_0100_1010;
`endif
    apply_stimulus(8'hA5, 2'b01);
    valid = 2'b00;
    record(0, 60);
    for (int b = 0; b < FRAME / CPB; b++)
      check_output($sformatf("a5 bit%0d", b), 32'(line_s[CPB * b + 1]), 32'(a5_bits[b]));
    cnt = 0;
    for (int i = 0; i < 60; i++) cnt += int'(busy_s[i]);
    check_output("a5 busy cycles", 32'(cnt), 32'(FRAME));
    check_output("a5 busy falls", 32'(busy_s[FRAME]), 32'd0);

    // 0x00 on the two-stop-bit lane
    apply_stimulus(8'h00, 2'b10);
    valid = 2'b00;
    record(1, 60);
    cnt  = 0;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      cnt += int'(busy_s[i]);
      if (busy_s[i] && line_s[i]) lows++;
    end
    check_output("stop2 busy cycles", 32'(cnt), 32'(FRAME + CPB));
    check_output("stop2 high cycles", 32'(lows), 32'(2 * CPB));

    // 0x01 then 0xFF back to back on lane 0
    apply_stimulus(8'h01, 2'b01);
    apply_stimulus(8'hFF, 2'b01);
    valid = 2'b00;
    check_output("b2b held rdy", 32'(rdy[0]), 32'd0);
    record(0, 100);
    check_output("b2b last stop", 32'(line_s[FRAME - 2]), 32'd1);
    check_output("b2b second start", 32'(line_s[FRAME - 1]), 32'd0);
    check_output("b2b second bit0", 32'(line_s[FRAME + CPB]), 32'd1);
    cnt = 0;
    for (int i = 0; i < 100; i++) cnt += int'(busy_s[i]);
    check_output("b2b busy cycles", 32'(cnt), 32'(2 * FRAME - 1));

    // reset during data bit 3 with a byte queued
    apply_stimulus(8'h3C, 2'b01);
    apply_stimulus(8'h55, 2'b01);
    valid = 2'b00;
    repeat (16) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_output("rst tx_o", 32'(line[0]), 32'd1);
    check_output("rst rdy", 32'(rdy[0]), 32'd1);
    check_output("rst busy", 32'(busy[0]), 32'd0);
    record(0, 60);
    lows = 0;
    cnt  = 0;
    for (int i = 0; i < 60; i++) begin
      if (!line_s[i]) lows++;
      cnt += int'(busy_s[i]);
    end
    check_output("rst queued dropped", 32'(lows), 32'd0);
    check_output("rst stays idle", 32'(cnt), 32'd0);

    // valid held high with changing data, both lanes
    for (int i = 0; i < 200; i++) apply_stimulus(8'($urandom), 2'b11);

    // fully random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      apply_stimulus(8'($urandom), {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0)});
    end
    rst   = 1'b0;
    valid = 2'b00;
    repeat (120) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, LSB first.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 104, clk_i cycles per bit (minimum 2).
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits (1 or 2 only).
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tx_i  input  DATA_WIDTH  byte to transmit.
REQ-007 SHALL have port tx_i_v  input  1  tx_i valid; transfer occurs on any edge where tx_i_v=1 and tx_i_rdy=1.
REQ-008 SHALL have port tx_i_rdy  output  1  holding register empty, can accept a byte.
REQ-009 SHALL have port tx_o  output  1  serial line, idle high, registered.
REQ-010 SHALL have port tx_o_v  output  1  busy: high while a frame is on the line or the holding register is full.

Function
REQ-011 SHALL use a one-entry holding register plus a shift register, so one byte can be queued while another is shifting.
REQ-012 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-013 SHALL hold every bit for exactly CLKS_PER_BIT cycles using a baud counter that counts 0..CLKS_PER_BIT-1 and restarts on each bit boundary.
REQ-014 SHALL, in IDLE with the holding register empty, load an accepted byte directly into the shifter and enter START, driving tx_o=0 from the next edge (1-cycle latency).
REQ-015 SHALL, in IDLE with the holding register full, move its contents into the shifter and enter START on the next edge.
REQ-016 SHALL, in DATA, shift out DATA_WIDTH bits LSB first, then go to PARITY when parity is compiled in, otherwise to STOP.
REQ-017 SHALL drive tx_o=1 in STOP for STOP_BITS*CLKS_PER_BIT cycles.
REQ-018 SHALL, at the end of STOP, go directly to START with no idle gap when a byte is waiting (holding register full, or accepted on that same edge); otherwise go to IDLE.
REQ-019 SHALL accept at most one byte per edge; a byte presented while tx_i_rdy=0 SHALL be ignored with no effect on the line.
REQ-020 SHALL drive tx_i_rdy=0 from the edge after a byte enters the holding register until the edge after it moves to the shifter.
REQ-021 SHALL give tx_o_v=0 only in IDLE with the holding register empty; it SHALL rise on the edge following acceptance.
REQ-022 SHALL ignore tx_i while tx_i_v=0 or no transfer occurs; the captured value SHALL be frozen at acceptance.

Reset
REQ-023 SHALL, on rst_i=1 at an edge, enter IDLE, clear the baud and bit counters, empty the holding register, and set tx_o=1, tx_i_rdy=1, tx_o_v=0.
REQ-024 SHALL, on reset mid-frame, abort the frame: tx_o=1 from the next edge, and any queued byte is discarded.
REQ-025 SHALL accept no transfer on an edge where rst_i=1, even if tx_i_v=1.

Configuration
REQ-026 SHALL, with macro UART_PARITY_EN defined, insert one parity bit after the data bits for CLKS_PER_BIT cycles; it is even parity (XOR of data bits), odd when parameter PARITY_ODD (default 0) is 1.
REQ-027 SHALL, without UART_PARITY_EN, omit the PARITY state, the parity logic and the PARITY_ODD parameter; frame = start + data + stop.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-028 SHALL cover: single byte 0xA5 from idle -> tx_o low 1 cycle after acceptance, bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles, tx_o_v falls after stop; 40 cycles total without parity.
REQ-029 SHALL cover: 0x01 then 0xFF offered back-to-back -> second byte held (tx_i_rdy=0), its start bit immediately follows the first stop bit, no gap.
REQ-030 SHALL cover: UART_PARITY_EN defined, 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; frame 44 cycles.
REQ-031 SHALL cover: rst_i pulsed during data bit 3 with a byte queued -> tx_o=1 the next cycle, tx_i_rdy=1, tx_o_v=0, and the queued byte is never sent.
REQ-032 SHALL cover: tx_i_v held high with changing tx_i while tx_i_rdy=0 -> only the bytes accepted on ready edges appear on the line.
REQ-033 SHALL cover: STOP_BITS=2, 0x00 -> stop high 8 cycles before tx_o_v falls.
